// File: rtl/tor_lookup_pkg.sv
// Shared types, encodings and the MAC classify function for tor_port_lookup.
package tor_lookup_pkg;

  localparam int MAC_W = 48;
  localparam int ID_W  = 4;
  localparam int TOR_W = 3;

  typedef enum logic [1:0] {
    SEEK_LOCAL  = 2'b00,
    SEEK_DIRECT = 2'b01,
    SEEK_BUFFER = 2'b10,
    SEEK_DROP   = 2'b11
  } seek_e;

  typedef struct packed {
    seek_e            seek;
    logic [TOR_W-1:0] outport;
  } lookup_res_t;

  function automatic lookup_res_t classify(
    input logic [MAC_W-1:0] mac,
    input logic [31:0]      head,
    input logic [TOR_W-1:0] my_tor,
    input logic [7:0]       down,
    input logic [TOR_W-1:0] cur_tor,
    input logic             conn_ok
  );
    lookup_res_t      r;
    logic [TOR_W-1:0] tor;
    logic [7:0]       pb;
    tor       = mac[8 +: TOR_W];
    pb        = mac[7:0];
    r.seek    = SEEK_DROP;
    r.outport = '0;
    if (mac[47:16] != head || mac[15:8] > 8'd7) begin
      r.seek = SEEK_DROP;
    end else if (tor == my_tor) begin
      if (pb != 8'd0 && pb <= down) begin
        r.seek    = SEEK_LOCAL;
        r.outport = TOR_W'(pb - 8'd1);
      end
    end else if (conn_ok && tor == cur_tor) begin
      r.seek    = SEEK_DIRECT;
      r.outport = tor;
    end else begin
      r.seek    = SEEK_BUFFER;
      r.outport = tor;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or above ptr,
// else lowest request overall. One-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                       req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                       gnt
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] hi;
  logic [N-1:0] pick;

  always_comb begin
    hi   = req & ~((ONE << ptr) - ONE);
    pick = (|hi) ? hi : req;
    gnt  = pick & (~pick + ONE);
  end

endmodule

// File: rtl/tor_port_lookup.sv
// Shared dst-MAC lookup for the ToR RX ports: pending regs, RR grant, classify.
// Optional LOOKUP_STATS_EN adds saturating per-class result counters.
module tor_port_lookup
  import tor_lookup_pkg::*;
#(
  parameter int          P_PORT_NUM   = 4,
  parameter logic [31:0] P_MAC_HEAD   = 32'h8DBC5C4A,
  parameter logic [2:0]  P_MY_TOR_ID  = 3'd0,
  parameter int          P_DOWN_PORTS = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [MAC_W*P_PORT_NUM-1:0]   i_check_mac,
  input  logic [ID_W*P_PORT_NUM-1:0]    i_check_id,
  input  logic [P_PORT_NUM-1:0]         i_check_valid,
  input  logic [TOR_W-1:0]              i_cur_connect_tor,
  input  logic                          i_connect_valid,
  output logic [P_PORT_NUM-1:0]         o_result_valid,
  output logic [TOR_W-1:0]              o_outport,
  output logic [1:0]                    o_seek_flag,
  output logic [ID_W-1:0]               o_check_id,
  output logic [P_PORT_NUM-1:0]         o_req_overflow
`ifdef LOOKUP_STATS_EN
  ,
  output logic [31:0]                   o_cnt_local,
  output logic [31:0]                   o_cnt_direct,
  output logic [31:0]                   o_cnt_buffer,
  output logic [31:0]                   o_cnt_drop
`endif
);

  localparam int PW = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;

  logic [P_PORT_NUM-1:0] pend;
  logic [P_PORT_NUM-1:0] gnt;
  logic [MAC_W-1:0]      pmac [P_PORT_NUM];
  logic [ID_W-1:0]       pid  [P_PORT_NUM];
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;

  logic                  s1_vld;
  logic [MAC_W-1:0]      s1_mac;
  logic [ID_W-1:0]       s1_id;
  logic [PW-1:0]         s1_port;
  lookup_res_t           res;

  rr_arbiter #(
    .N(P_PORT_NUM)
  ) u_arb (
    .req(pend),
    .ptr(ptr),
    .gnt(gnt)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < P_PORT_NUM; i++)
      if (gnt[i]) gidx = PW'(i);
  end

  // A new strobe always wins the slot; the granted copy already left.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend           <= '0;
      o_req_overflow <= '0;
      for (int i = 0; i < P_PORT_NUM; i++) begin
        pmac[i] <= '0;
        pid[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < P_PORT_NUM; i++) begin
        if (i_check_valid[i]) begin
          pend[i] <= 1'b1;
          pmac[i] <= i_check_mac[MAC_W*i +: MAC_W];
          pid[i]  <= i_check_id[ID_W*i +: ID_W];
          if (pend[i] && !gnt[i])
            o_req_overflow[i] <= 1'b1;
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr     <= '0;
      s1_vld  <= 1'b0;
      s1_mac  <= '0;
      s1_id   <= '0;
      s1_port <= '0;
    end else begin
      s1_vld <= |gnt;
      if (|gnt) begin
        ptr     <= (gidx == PW'(P_PORT_NUM - 1)) ? '0 : gidx + 1'b1;
        s1_mac  <= pmac[gidx];
        s1_id   <= pid[gidx];
        s1_port <= gidx;
      end
    end
  end

  always_comb
    res = classify(s1_mac, P_MAC_HEAD, P_MY_TOR_ID,
                   8'(P_DOWN_PORTS), i_cur_connect_tor,
                   i_connect_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result_valid <= '0;
      o_outport      <= '0;
      o_seek_flag    <= '0;
      o_check_id     <= '0;
    end else begin
      o_result_valid <= '0;
      if (s1_vld) begin
        o_result_valid <= P_PORT_NUM'(1) << s1_port;
        o_outport      <= res.outport;
        o_seek_flag    <= res.seek;
        o_check_id     <= s1_id;
      end
    end
  end

`ifdef LOOKUP_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_local  <= '0;
      o_cnt_direct <= '0;
      o_cnt_buffer <= '0;
      o_cnt_drop   <= '0;
    end else if (s1_vld) begin
      unique case (res.seek)
        SEEK_LOCAL:
          if (o_cnt_local != '1)
            o_cnt_local <= o_cnt_local + 1'b1;
        SEEK_DIRECT:
          if (o_cnt_direct != '1)
            o_cnt_direct <= o_cnt_direct + 1'b1;
        SEEK_BUFFER:
          if (o_cnt_buffer != '1)
            o_cnt_buffer <= o_cnt_buffer + 1'b1;
        SEEK_DROP:
          if (o_cnt_drop != '1)
            o_cnt_drop <= o_cnt_drop + 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tor_port_lookup.sv
// Bench for tor_port_lookup: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_tor_port_lookup;

  localparam int          NP   = 4;
  localparam logic [31:0] HEAD = 32'h8DBC5C4A;
  localparam int          MYT  = 0;
  localparam int          DOWN = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [48*NP-1:0]  chk_mac;
  logic [4*NP-1:0]   chk_id;
  logic [NP-1:0]     chk_valid;
  logic [2:0]        cur_tor;
  logic              conn_v;
  logic [NP-1:0]     o_result_valid;
  logic [2:0]        o_outport;
  logic [1:0]        o_seek_flag;
  logic [3:0]        o_check_id;
  logic [NP-1:0]     o_req_overflow;
`ifdef LOOKUP_STATS_EN
  logic [31:0]       o_cnt_local, o_cnt_direct;
  logic [31:0]       o_cnt_buffer, o_cnt_drop;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tor_port_lookup dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_check_mac      (chk_mac),
    .i_check_id       (chk_id),
    .i_check_valid    (chk_valid),
    .i_cur_connect_tor(cur_tor),
    .i_connect_valid  (conn_v),
    .o_result_valid   (o_result_valid),
    .o_outport        (o_outport),
    .o_seek_flag      (o_seek_flag),
    .o_check_id       (o_check_id),
    .o_req_overflow   (o_req_overflow)
`ifdef LOOKUP_STATS_EN
    ,
    .o_cnt_local      (o_cnt_local),
    .o_cnt_direct     (o_cnt_direct),
    .o_cnt_buffer     (o_cnt_buffer),
    .o_cnt_drop       (o_cnt_drop)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference classification straight from the class table.
  function automatic logic [4:0] ref_class(input logic [47:0] mac,
                                           input int cur,
                                           input logic cv);
    int h, t, b;
    h = int'(mac >> 16);
    t = int'((mac >> 8) & 48'hFF);
    b = int'(mac & 48'hFF);
    if (h != int'(HEAD) || t > 7) return {2'b11, 3'd0};
    if (t == MYT) begin
      if (b >= 1 && b <= DOWN) return {2'b00, 3'(b - 1)};
      return {2'b11, 3'd0};
    end
    if (cv && t == cur) return {2'b01, 3'(t)};
    return {2'b10, 3'(t)};
  endfunction

  bit          m_pend [NP];
  logic [47:0] m_mac  [NP];
  logic [3:0]  m_id   [NP];
  int          m_ptr, g, q;
  bit          m_s1v;
  logic [47:0] m_s1mac;
  logic [3:0]  m_s1id;
  int          m_s1p;
  logic [4:0]  cls;
  logic [NP-1:0] e_valid, e_ovf;
  logic [2:0]  e_outport;
  logic [1:0]  e_seek;
  logic [3:0]  e_id;
  longint      e_cnt [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        m_pend[p] = 0; m_mac[p] = '0; m_id[p] = '0;
      end
      m_ptr = 0; m_s1v = 0; m_s1mac = '0; m_s1id = '0; m_s1p = 0;
      e_valid = '0; e_ovf = '0; e_outport = '0;
      e_seek = '0; e_id = '0;
      for (int k = 0; k < 4; k++) e_cnt[k] = 0;
    end else begin
      e_valid = '0;
      if (m_s1v) begin
        cls = ref_class(m_s1mac, int'(cur_tor), conn_v);
        e_valid = NP'(1) << m_s1p;
        e_seek = cls[4:3];
        e_outport = cls[2:0];
        e_id = m_s1id;
        if (e_cnt[cls[4:3]] < 64'hFFFF_FFFF) e_cnt[cls[4:3]]++;
      end
      g = -1;
      for (int k = 0; k < NP; k++) begin
        q = (m_ptr + k) % NP;
        if (g < 0 && m_pend[q]) g = q;
      end
      m_s1v = (g >= 0);
      if (g >= 0) begin
        m_s1mac = m_mac[g]; m_s1id = m_id[g]; m_s1p = g;
        m_ptr = (g + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin
        if (chk_valid[p]) begin
          if (m_pend[p] && p != g) e_ovf[p] = 1'b1;
          m_pend[p] = 1;
          m_mac[p] = chk_mac[48*p +: 48];
          m_id[p] = chk_id[4*p +: 4];
        end else if (p == g) begin
          m_pend[p] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("m_valid", 64'(o_result_valid), 64'(e_valid));
    check("m_outport", 64'(o_outport), 64'(e_outport));
    check("m_seek", 64'(o_seek_flag), 64'(e_seek));
    check("m_id", 64'(o_check_id), 64'(e_id));
    check("m_ovf", 64'(o_req_overflow), 64'(e_ovf));
`ifdef LOOKUP_STATS_EN
    check("m_cnt_local", 64'(o_cnt_local), 64'(e_cnt[0]));
    check("m_cnt_direct", 64'(o_cnt_direct), 64'(e_cnt[1]));
    check("m_cnt_buffer", 64'(o_cnt_buffer), 64'(e_cnt[2]));
    check("m_cnt_drop", 64'(o_cnt_drop), 64'(e_cnt[3]));
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input int p, input logic [47:0] mac,
                     input logic [3:0] id);
    chk_valid[p] = 1'b1;
    chk_mac[48*p +: 48] = mac;
    chk_id[4*p +: 4] = id;
  endtask

  // Issue one request and land on the negedge after its result edge.
  task automatic one(input int p, input logic [47:0] mac,
                     input logic [3:0] id);
    req(p, mac, id);
    tick();
    chk_valid = '0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic expect_res(input string tag, input logic [3:0] v,
                            input logic [1:0] s, input logic [2:0] o,
                            input logic [3:0] id);
    check({tag, "_valid"}, 64'(o_result_valid), 64'(v));
    check({tag, "_seek"}, 64'(o_seek_flag), 64'(s));
    check({tag, "_outport"}, 64'(o_outport), 64'(o));
    check({tag, "_id"}, 64'(o_check_id), 64'(id));
  endtask

  function automatic logic [47:0] rnd_mac();
    logic [31:0] h;
    logic [7:0]  t, b;
    h = HEAD;
    if ($urandom_range(0, 5) == 0) h = HEAD ^ (32'h1 << $urandom_range(0, 31));
    t = 8'($urandom_range(0, 7));
    if ($urandom_range(0, 2) == 0) t = 8'(MYT);
    if ($urandom_range(0, 9) == 0) t = 8'($urandom_range(8, 255));
    b = 8'($urandom_range(0, 3));
    return {h, t, b};
  endfunction

  initial begin
    rst_n = 1'b0;
    chk_mac = '0; chk_id = '0; chk_valid = '0;
    cur_tor = 3'd0; conn_v = 1'b0;
    tick(); tick(); tick();
    check("rst_valid", 64'(o_result_valid), 64'h0);
    check("rst_outport", 64'(o_outport), 64'h0);
    check("rst_seek", 64'(o_seek_flag), 64'h0);
    check("rst_id", 64'(o_check_id), 64'h0);
    check("rst_ovf", 64'(o_req_overflow), 64'h0);
    #2 rst_n = 1'b1;
    tick();

    // local hit, exact latency
    req(0, 48'h8DBC5C4A_0002, 4'h5);
    tick();
    chk_valid = '0;
    tick();
    check("t1_early", 64'(o_result_valid), 64'h0);
    tick();
    expect_res("t1", 4'b0001, 2'b00, 3'd1, 4'h5);
    tick();
    check("t1_pulse", 64'(o_result_valid), 64'h0);
    check("t1_hold", 64'(o_outport), 64'h1);

    cur_tor = 3'd3; conn_v = 1'b1;
    one(1, 48'h8DBC5C4A_0301, 4'h6);
    expect_res("t2_direct", 4'b0010, 2'b01, 3'd3, 4'h6);
    conn_v = 1'b0;
    one(1, 48'h8DBC5C4A_0301, 4'h7);
    expect_res("t2_buffer", 4'b0010, 2'b10, 3'd3, 4'h7);

    // bursts on all ports from ptr 0
    do_reset();
    conn_v = 1'b1;
    for (int r = 0; r < 2; r++) begin
      req(0, 48'h8DBC5C4A_0001, 4'(1 + 8*r));
      req(1, 48'h8DBC5C4A_0301, 4'(2 + 8*r));
      req(2, 48'h8DBC5C4A_0501, 4'(3 + 8*r));
      req(3, 48'h8DBC5C4B_0001, 4'(4 + 8*r));
      tick();
      chk_valid = '0;
      tick();
      tick();
      expect_res("t3_p0", 4'b0001, 2'b00, 3'd0, 4'(1 + 8*r));
      tick();
      expect_res("t3_p1", 4'b0010, 2'b01, 3'd3, 4'(2 + 8*r));
      tick();
      expect_res("t3_p2", 4'b0100, 2'b10, 3'd5, 4'(3 + 8*r));
      tick();
      expect_res("t3_p3", 4'b1000, 2'b11, 3'd0, 4'(4 + 8*r));
      tick();
    end
`ifdef LOOKUP_STATS_EN
    check("t3_cnt_local", 64'(o_cnt_local), 64'd2);
    check("t3_cnt_direct", 64'(o_cnt_direct), 64'd2);
    check("t3_cnt_buffer", 64'(o_cnt_buffer), 64'd2);
    check("t3_cnt_drop", 64'(o_cnt_drop), 64'd2);
`endif

    one(2, 48'h8DBC5C4B_0001, 4'hA);
    expect_res("t4_head", 4'b0100, 2'b11, 3'd0, 4'hA);
    one(0, 48'h8DBC5C4A_0000, 4'hB);
    expect_res("t4_byte0", 4'b0001, 2'b11, 3'd0, 4'hB);
    one(3, 48'h8DBC5C4A_0003, 4'hC);
    expect_res("t4_byte3", 4'b1000, 2'b11, 3'd0, 4'hC);
    one(1, 48'h8DBC5C4A_0801, 4'hD);
    expect_res("t4_tor8", 4'b0010, 2'b11, 3'd0, 4'hD);

    // port 2 overwritten while 0 and 1 are ahead of it
    do_reset();
    req(0, 48'h8DBC5C4A_0001, 4'h1);
    req(1, 48'h8DBC5C4A_0002, 4'h2);
    req(2, 48'h8DBC5C4A_0201, 4'h3);
    tick();
    chk_valid = '0;
    req(2, 48'h8DBC5C4A_0002, 4'h9);
    tick();
    chk_valid = '0;
    check("t5_ovf", 64'(o_req_overflow), 64'b0100);
    tick();
    tick();
    tick();
    expect_res("t5_second", 4'b0100, 2'b00, 3'd1, 4'h9);
    tick();
    check("t5_single", 64'(o_result_valid), 64'h0);

    // reset with requests pending
    req(0, 48'h8DBC5C4A_0001, 4'h1);
    req(1, 48'h8DBC5C4A_0002, 4'h2);
    req(3, 48'h8DBC5C4A_0101, 4'h4);
    tick();
    chk_valid = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_quiet", 64'(o_result_valid), 64'h0);
    end

    for (int k = 0; k < 500; k++) begin
      chk_valid = NP'($urandom) & NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        chk_mac[48*p +: 48] = rnd_mac();
        chk_id[4*p +: 4] = 4'($urandom);
      end
      cur_tor = 3'($urandom);
      conn_v = 1'($urandom);
      tick();
    end
    chk_valid = '0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
